// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Constants shared between the pipelined reciprocal divider
//               and its post-processing block.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    localparam int          M            = 4;
    localparam int          SERIES       = 5;
    localparam int          M_ACTIVE_MIN = 2;
    localparam int          DIV_MIN      = 2 ** (M_ACTIVE_MIN - 1);
    localparam logic [5:0]  DIVIDEND     = 6'b11_1111;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/divider_post_fifo.sv
`default_nettype none
// ============================================================================
// Module      : divider_post_fifo
// Description : Single-clock result FIFO with occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_post_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_full;
    logic               w_do_pop;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_do_pop = pop && (r_count != '0);
    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(push && w_full && !w_do_pop))
                else $error("divider_post_fifo: push into full FIFO");
        end
    end

endmodule
`default_nettype wire

// File: rtl/divider_post.sv
`default_nettype none
// ============================================================================
// Module      : divider_post
// Description : Aligns divider results with their divisors, rounds, flags
//               illegal divisors and buffers results behind a credit check.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_post
    import divider_pkg::is_pow2;
#(
    parameter int M       = divider_pkg::M,
    parameter int SERIES  = divider_pkg::SERIES,
    parameter int DEPTH   = 8,
    parameter int DIV_MIN = divider_pkg::DIV_MIN
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [M-1:0]      in_divisor,
    output logic              in_ready,
    input  logic [SERIES-1:0] merchant,
    input  logic [M-1:0]      remainder,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SERIES-1:0] out_quot,
    output logic [M-1:0]      out_rem,
    output logic [SERIES-1:0] out_quot_rnd,
    output logic              out_err
);

    localparam int                c_word_w    = SERIES + M + SERIES + 1;
    localparam int                c_cnt_w     = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w:0]  c_depth_lim = DEPTH[c_cnt_w:0];
    localparam logic [M-1:0]      c_div_min   = DIV_MIN[M-1:0];
    localparam logic [SERIES-1:0] c_quot_max  = '1;

    logic                         w_issue;
    logic                         w_capture;
    logic                         w_pop;
    logic [SERIES-1:0]            r_vld_line;
    logic [SERIES-1:0][M-1:0]     r_div_line;
    logic [M-1:0]                 w_cap_div;
    logic [c_cnt_w-1:0]           r_inflight;
    logic [c_cnt_w-1:0]           w_fifo_count;
    logic [c_cnt_w:0]             w_outstanding;
    logic                         w_err;
    logic                         w_round_up;
    logic [SERIES-1:0]            w_quot;
    logic [M-1:0]                 w_rem;
    logic [SERIES-1:0]            w_rnd;
    logic [c_word_w-1:0]          w_push_word;
    logic [c_word_w-1:0]          w_head_word;

    assign w_issue       = in_valid && in_ready;
    assign w_capture     = r_vld_line[SERIES-1];
    assign w_cap_div     = r_div_line[SERIES-1];
    assign w_outstanding = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign in_ready      = (w_outstanding < c_depth_lim);
    assign out_valid     = (w_fifo_count != '0);
    assign w_pop         = out_valid && out_ready;

    // The delay line mirrors the divider pipeline so a result meets its divisor.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_line <= '0;
            r_div_line <= '0;
        end else begin
            r_vld_line <= {r_vld_line[SERIES-2:0], w_issue};
            r_div_line <= {r_div_line[SERIES-2:0], in_divisor};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_capture})
                2'b10:   r_inflight <= r_inflight + c_cnt_w'(1);
                2'b01:   r_inflight <= r_inflight - c_cnt_w'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_comb begin
        w_err      = (w_cap_div < c_div_min);
        w_round_up = ({remainder, 1'b0} >= {1'b0, w_cap_div});
        w_quot     = merchant;
        w_rem      = remainder;
        if (merchant == c_quot_max) begin
            w_rnd = c_quot_max;
        end else begin
            w_rnd = merchant + SERIES'(w_round_up);
        end
        // Divider output is meaningless for an illegal divisor.
        if (w_err) begin
            w_quot = c_quot_max;
            w_rem  = '0;
            w_rnd  = c_quot_max;
        end
    end

    assign w_push_word = {w_quot, w_rem, w_rnd, w_err};

    divider_post_fifo #(
        .WIDTH (c_word_w),
        .DEPTH (DEPTH),
        .CNT_W (c_cnt_w)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_capture),
        .push_data (w_push_word),
        .pop       (w_pop),
        .pop_data  (w_head_word),
        .count     (w_fifo_count)
    );

    assign {out_quot, out_rem, out_quot_rnd, out_err} = out_valid ? w_head_word : '0;

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (DEPTH >= SERIES + 1 && is_pow2(DEPTH))
                else $error("divider_post: illegal DEPTH");
            assert (w_outstanding <= c_depth_lim)
                else $error("divider_post: credit overrun");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divider_post.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_post
// Description : Scoreboard bench for divider_post with a 5-cycle divider model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_divider_post;
    import divider_pkg::*;

    localparam int c_depth = 8;
    localparam int c_w     = SERIES + M + SERIES + 1;

    logic              clk        = 1'b0;
    logic              rstn       = 1'b0;
    logic              in_valid   = 1'b0;
    logic [M-1:0]      in_divisor = '0;
    logic              out_ready  = 1'b0;
    logic              in_ready;
    logic [SERIES-1:0] merchant;
    logic [M-1:0]      remainder;
    logic              out_valid;
    logic [SERIES-1:0] out_quot;
    logic [M-1:0]      out_rem;
    logic [SERIES-1:0] out_quot_rnd;
    logic              out_err;

    int               vectors     = 0;
    int               miscompares = 0;
    logic [c_w-1:0]   sb[$];
    logic [M-1:0]     model_pipe [SERIES] = '{default: '0};

    divider_post #(
        .M       (M),
        .SERIES  (SERIES),
        .DEPTH   (c_depth),
        .DIV_MIN (DIV_MIN)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_divisor   (in_divisor),
        .in_ready     (in_ready),
        .merchant     (merchant),
        .remainder    (remainder),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quot     (out_quot),
        .out_rem      (out_rem),
        .out_quot_rnd (out_quot_rnd),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;

    // Divider model: registers the divisor every cycle, result after SERIES edges.
    always @(posedge clk) begin
        model_pipe[0] <= in_divisor;
        for (int i = 1; i < SERIES; i++) model_pipe[i] <= model_pipe[i-1];
    end

    always_comb begin
        int d;
        d = int'(model_pipe[SERIES-1]);
        merchant  = 5'h0a;
        remainder = 4'h5;
        if (d >= DIV_MIN) begin
            merchant  = SERIES'(int'(DIVIDEND) / d);
            remainder = M'(int'(DIVIDEND) % d);
        end
    end

    function automatic logic [c_w-1:0] expect_word(input logic [M-1:0] dv);
        int d, q, r, n;
        logic e;
        d = int'(dv);
        if (d < DIV_MIN) begin
            q = (1 << SERIES) - 1;
            r = 0;
            n = q;
            e = 1'b1;
        end else begin
            q = 63 / d;
            r = 63 % d;
            n = q + ((2 * r >= d) ? 1 : 0);
            if (n > (1 << SERIES) - 1) n = (1 << SERIES) - 1;
            e = 1'b0;
        end
        return {SERIES'(q), M'(r), SERIES'(n), e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [M-1:0] d, input logic rdy);
        @(negedge clk);
        in_valid   = v;
        in_divisor = d;
        out_ready  = rdy;
        #1;
        chk("credit", 32'(in_ready), 32'(sb.size() < c_depth));
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious", 32'(out_valid), 32'(0));
            end else begin
                chk(out_ready ? "pop" : "hold",
                    32'({out_quot, out_rem, out_quot_rnd, out_err}), 32'(sb[0]));
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (in_valid && in_ready) sb.push_back(expect_word(d));
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) step(1'b0, '0, 1'b1);
        chk("drain", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;

        #2;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_ready", 32'(in_ready), 32'(1));
        chk("rst_data", 32'({out_quot, out_rem, out_quot_rnd, out_err}), 32'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Single issue: first out_valid six cycles later.
        step(1'b1, 4'd5, 1'b1);
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step(1'b0, '0, 1'b1);
            if (out_valid) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        chk("latency", 32'(lat), 32'(6));
        drain(20);

        // Back-to-back, saturation and illegal divisors.
        step(1'b1, 4'd7, 1'b1);
        step(1'b1, 4'd15, 1'b1);
        step(1'b1, 4'd8, 1'b1);
        drain(20);
        step(1'b1, 4'd2, 1'b1);
        step(1'b1, 4'd0, 1'b1);
        step(1'b1, 4'd1, 1'b1);
        drain(20);

        // Back-pressure: nine attempts, eight accepted.
        for (int i = 0; i < 9; i++) step(1'b1, M'(3 + i), 1'b0);
        chk("accepted", 32'(sb.size()), 32'(8));
        chk("full_ready", 32'(in_ready), 32'(0));
        repeat (8) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("pop_cycle_ready", 32'(in_ready), 32'(0));
        step(1'b0, '0, 1'b0);
        chk("repop_ready", 32'(in_ready), 32'(1));
        drain(40);

        // Reset with two buffered and three in flight.
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd6, 1'b0);
        repeat (6) step(1'b0, '0, 1'b0);
        step(1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        step(1'b1, 4'd11, 1'b0);
        #2;
        rstn     = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_ready", 32'(in_ready), 32'(1));
        chk("midrst_data", 32'({out_quot, out_rem, out_quot_rnd, out_err}), 32'(0));
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (12) step(1'b0, '0, 1'b1);

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            step(1'($urandom_range(0, 1)), M'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0));
        end
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divider_post.md
DIVIDER_POST -- requirements
Module: divider_post

Interface
REQ-001 Parameter M, default 4: divisor and remainder width, matching the pipelined reciprocal divider.
REQ-002 Parameter SERIES, default 5: quotient width, which also equals the divider latency in cycles.
REQ-003 Parameter DEPTH, default 8: result FIFO depth; legal only when DEPTH >= SERIES+1 and DEPTH is a power of 2.
REQ-004 Parameter DIV_MIN, default 2: smallest legal divisor, equal to 2^(M_ACTIVE_MIN-1).
REQ-005 clk  input  1  single clock; all state is updated on the rising edge.
REQ-006 rstn  input  1  reset, asynchronous and active-low.
REQ-007 in_valid  input  1  upstream is issuing a divisor to the divider this cycle.
REQ-008 in_divisor  input  M  the same divisor value driven to the divider in the same cycle.
REQ-009 in_ready  output  1  issue permitted; upstream SHALL issue only when in_valid and in_ready are both high.
REQ-010 merchant  input  SERIES  divider quotient output.
REQ-011 remainder  input  M  divider remainder output.
REQ-012 out_valid  output  1  FIFO head is valid.
REQ-013 out_ready  input  1  downstream accepts the head this cycle.
REQ-014 out_quot  output  SERIES  truncated quotient.
REQ-015 out_rem  output  M  remainder.
REQ-016 out_quot_rnd  output  SERIES  round-half-up quotient.
REQ-017 out_err  output  1  divisor was below DIV_MIN.

Function
REQ-018 An issue is the event in_valid & in_ready.
REQ-019 The block SHALL carry a SERIES-deep valid/divisor delay line, so the divider result for an issue at edge t is captured at edge t+SERIES.
REQ-020 Capture SHALL write {quot, rem, rnd, err} into the FIFO.
REQ-021 If the FIFO was empty, out_valid SHALL rise one cycle after capture.
REQ-022 in_ready SHALL be high iff (FIFO occupancy + in-flight count) < DEPTH, evaluated combinationally from registered counters.
REQ-023 A pop in the current cycle SHALL NOT raise in_ready in that same cycle.
REQ-024 The in-flight count SHALL increment on issue and decrement on capture; on simultaneous issue and capture it SHALL be unchanged.
REQ-025 The FIFO SHALL pop on out_valid & out_ready.
REQ-026 Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
REQ-027 A push to a full FIFO SHALL be impossible by construction, and an assertion SHALL flag it.
REQ-028 Rounding: out_quot_rnd = quot + ({rem,1'b0} >= divisor), computed at M+1 bits and saturating at all-ones.
REQ-029 Error: if the divisor < DIV_MIN (including 0), set err=1, force quot = out_quot_rnd = all-ones, and force rem = 0; divider outputs are ignored for that entry.
REQ-030 Ordering SHALL be strictly FIFO, with no reordering or dropping.
REQ-031 out_quot, out_rem, out_quot_rnd and out_err SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-032 rstn low SHALL immediately clear the delay line, in-flight count, FIFO pointers and occupancy.
REQ-033 During reset, out_valid SHALL be 0, in_ready SHALL be 1, and data outputs SHALL be 0.
REQ-034 Reset mid-operation SHALL discard all in-flight and buffered results; divider outputs arriving after release SHALL NOT be captured, because the delay line is cleared.
REQ-035 Release SHALL be synchronized externally; the block has no internal synchronizer.

Structure
REQ-036 Package divider_pkg SHALL hold M, SERIES, M_ACTIVE_MIN, DIV_MIN and the dividend constant (6'b11_1111), shared with the divider.
REQ-037 One sub-module, divider_post_fifo: a synchronous FIFO of width SERIES+SERIES+M+1 and depth DEPTH with occupancy output, using single-clock async-low reset.
REQ-038 The delay line, credit counter and rounding logic SHALL live in the top level; target 150-300 lines total.

Verification (dividend 63, M=4, SERIES=5, DEPTH=8; bench uses a divider model with 5-cycle latency)
REQ-039 Issue divisor 5 at cycle 0 -> out_valid at cycle 6: quot 12, rem 3, rnd 13, err 0.
REQ-040 Back-to-back issues of 7, 15, 8 -> three consecutive outputs: (9,0,9), (4,3,4), (7,7,8).
REQ-041 Issue divisor 2 -> quot 31, rem 1, rnd 31 (saturated). Issue divisor 0 and divisor 1 -> err 1, quot all-ones, rem 0.
REQ-042 out_ready held 0 with 9 issue attempts -> exactly 8 accepted and in_ready low afterwards. One pop then re-raises in_ready the next cycle, and all outputs drain in order.
REQ-043 rstn pulsed low with 3 results in flight and 2 buffered -> out_valid 0 and in_ready 1 immediately; no stale output after release.
REQ-044 Random issue and random out_ready for 10k cycles -> scoreboard match, no overflow assertion, and occupancy + in-flight never exceeds 8.
